// File: rtl/dflop_pipe.sv
// Multi-bit D-flop delay line with stall, synchronous clear, per-stage valid
// tracking, a selectable tap and a registered occupancy count.
module dflop_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     TAP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned     CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CNT_W-1:0] fill_cnt,
    output logic             full
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_d;

    // Occupancy after an enabled edge: one item may enter while another leaves.
    always_comb begin
        fill_d = fill_q + CNT_W'(d_valid) - CNT_W'(valid_q[DEPTH-1]);
    end

    // Stage registers and count: async reset, then clear > advance > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= RESET_VAL;
                valid_q[i] <= 1'b0;
            end
            fill_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= RESET_VAL;
                valid_q[i] <= 1'b0;
            end
            fill_q <= '0;
        end else if (en) begin
            data_q[0]  <= d;
            valid_q[0] <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
            fill_q <= fill_d;
        end
    end

    // Tap mux; a select past the last stage reads as an empty reset stage.
    always_comb begin
        tap_q     = RESET_VAL;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                tap_q     = data_q[i];
                tap_valid = valid_q[i];
            end
        end
    end

    // Tail stage and count are driven straight from the flops.
    always_comb begin
        q        = data_q[DEPTH-1];
        q_valid  = valid_q[DEPTH-1];
        fill_cnt = fill_q;
        full     = (fill_q == CNT_W'(DEPTH));
    end

endmodule

// File: tb/tb_dflop_pipe.sv
// Self-checking bench for dflop_pipe: a queue scoreboard tracks every item in
// flight and is compared against q, the taps and the occupancy after each edge.
module tb_dflop_pipe;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, clr, d_valid;
    logic [7:0] d;
    logic [1:0] tap_sel, tap_sel3;

    logic [7:0] q, tap_q, q3, tap_q3;
    logic       q_valid, tap_valid, full, q_valid3, tap_valid3, full3;
    logic [2:0] fill_cnt;
    logic [1:0] fill_cnt3;

    dflop_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
        .tap_sel(tap_sel), .q(q), .q_valid(q_valid), .tap_q(tap_q),
        .tap_valid(tap_valid), .fill_cnt(fill_cnt), .full(full)
    );

    dflop_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
        .tap_sel(tap_sel3), .q(q3), .q_valid(q_valid3), .tap_q(tap_q3),
        .tap_valid(tap_valid3), .fill_cnt(fill_cnt3), .full(full3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: {valid,data} of stages 0..D-2 (back = stage 0), plus the tail.
    logic [8:0] mq[$];
    logic [8:0] mout;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < D - 1; i++) mq.push_back(9'h000);
        mout = 9'h000;
    endtask

    function automatic logic [8:0] stage_exp(input int j);
        if (j == D - 1) return mout;
        return mq[mq.size() - 1 - j];
    endfunction

    function automatic int pop_exp();
        int n = int'(mout[8]);
        foreach (mq[i]) n += int'(mq[i][8]);
        return n;
    endfunction

    task automatic check_outs(input string tag);
        int n = pop_exp();
        check($sformatf("%s_q", tag), 32'(q), 32'(mout[7:0]));
        check($sformatf("%s_qv", tag), 32'(q_valid), 32'(mout[8]));
        check($sformatf("%s_fill", tag), 32'(fill_cnt), 32'(n));
        check($sformatf("%s_full", tag), 32'(full), 32'(n == D));
    endtask

    task automatic sweep_tap(input string tag);
        for (int j = 0; j < D; j++) begin
            logic [8:0] s;
            tap_sel = 2'(j);
            #1;
            s = stage_exp(j);
            check($sformatf("%s_tap%0d", tag, j), 32'(tap_q), 32'(s[7:0]));
            check($sformatf("%s_tapv%0d", tag, j), 32'(tap_valid), 32'(s[8]));
        end
    endtask

    // One clock edge with the given controls; the scoreboard follows the edge.
    task automatic tick(input logic e, input logic c, input logic [7:0] dd, input logic dv,
                        input string tag);
        en = e; clr = c; d = dd; d_valid = dv;
        @(posedge clk);
        #1;
        if (c) model_reset();
        else if (e) begin
            mq.push_back({dv, dd});
            mout = mq.pop_front();
        end
        check_outs(tag);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; clr = 1'b0; d = '0; d_valid = 1'b0;
        tap_sel = '0; tap_sel3 = '0;

        // 1: async reset before any clock edge
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 2: latency and fill count
        tick(1, 0, 8'hA1, 1, "lat1");
        tick(1, 0, 8'hB2, 1, "lat2");
        tick(1, 0, 8'hC3, 1, "lat3");
        tick(1, 0, 8'hD4, 1, "lat4");
        check("lat_a1", 32'(q), 32'h0A1);
        check("lat_full", 32'(full), 32'd1);
        sweep_tap("lat");
        tick(1, 0, 8'h00, 0, "drain1");
        tick(1, 0, 8'h00, 0, "drain2");
        tick(1, 0, 8'h00, 0, "drain3");
        check("drain_d4", 32'(q), 32'h0D4);

        // 3: stall holds state; stall-time inputs are dropped
        tick(0, 1, 8'h00, 0, "clr3");
        tick(1, 0, 8'h31, 1, "st_in1");
        tick(1, 0, 8'h32, 1, "st_in2");
        for (int k = 0; k < 3; k++) tick(0, 0, 8'($urandom), 1, "stall");
        check("stall_fill", 32'(fill_cnt), 32'd2);
        sweep_tap("stall");
        tick(1, 0, 8'h00, 0, "res1");
        tick(1, 0, 8'h00, 0, "res2");
        check("res_31", 32'(q), 32'h031);
        tick(1, 0, 8'h00, 0, "res3");
        check("res_32", 32'(q), 32'h032);
        tick(1, 0, 8'h00, 0, "res4");

        // 4: clear beats stall and beats capture; overflow drops the oldest
        for (int k = 0; k < 5; k++) tick(1, 0, 8'h40 + 8'(k), 1, "fill");
        check("ovf_q", 32'(q), 32'h041);
        tick(0, 1, 8'h00, 0, "clr_stall");
        check("clr_full", 32'(full), 32'd0);
        sweep_tap("clr");
        tick(1, 0, 8'h55, 1, "pre_clr");
        tick(1, 1, 8'h99, 1, "clr_en");
        for (int k = 0; k < 4; k++) tick(1, 0, 8'h00, 0, "post_clr");

        // 5: bubbles keep their data but not their valid flag
        tick(0, 1, 8'h00, 0, "clr5");
        tick(1, 0, 8'h11, 1, "bub1");
        tick(1, 0, 8'h22, 0, "bub2");
        tick(1, 0, 8'h33, 1, "bub3");
        check("bub_fill", 32'(fill_cnt), 32'd2);
        sweep_tap("bub");
        tap_sel3 = 2'd3;
        #1;
        check("d3_oor_q", 32'(tap_q3), 32'h0);
        check("d3_oor_v", 32'(tap_valid3), 32'h0);
        tap_sel3 = 2'd2;
        #1;
        check("d3_tap2_q", 32'(tap_q3), 32'h011);
        check("d3_tap2_v", 32'(tap_valid3), 32'h1);
        check("d3_q", 32'(q3), 32'h011);
        check("d3_fill", 32'(fill_cnt3), 32'd2);

        // 6: async reset mid-operation, then latency from release
        for (int k = 0; k < 4; k++) tick(1, 0, 8'h70 + 8'(k), 1, "pre_rst");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outs("arst");
        sweep_tap("arst");
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 0, 8'hE5, 1, "post1");
        tick(1, 0, 8'h00, 0, "post2");
        tick(1, 0, 8'h00, 0, "post3");
        tick(1, 0, 8'h00, 0, "post4");
        check("post_e5", 32'(q), 32'h0E5);
        check("post_e5v", 32'(q_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
